// File: rtl/palette_dac.sv
// Purpose: palette lookup plus 444/555 colour expansion, with a shared CPU port to the palette RAM.
// Latency: one pixel (ce_pixel edge k index -> outputs after edge k+1); CPU dtack 2..3 clk after cs.
// Backpressure: none on pixels (they always win the RAM); the CPU is stalled via cpu_dtack_n.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   ce_pixel           pixel clock enable (never on two consecutive clk cycles)
//   cs, cpu_addr, cpu_rw, cpu_ds_n, cpu_din   68000-style palette access request
//   cpu_dout, cpu_dtack_n                     read data and active-low acknowledge
//   color_in, hblank_in, vblank_in            mixer pixel index and blanking
//   rgb_format                                0 = xRGB444, 1 = xRGB555
//   red, green, blue, hblank_out, vblank_out  expanded colour and delayed blanking
module palette_dac #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pixel,
  input  logic              cs,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [1:0]        cpu_ds_n,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_dtack_n,
  input  logic [13:0]       color_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              rgb_format,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hblank_out,
  output logic              vblank_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } cpu_state_t;

  cpu_state_t state, state_d;

  logic        grant;
  logic        rd_q;
  logic        dtack_d;
  logic [15:0] dout_d;

  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_we;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  logic [15:0]       ram_q;

  logic        pix_pend;
  logic [15:0] pix_word;
  logic        hb1;
  logic        vb1;
  logic [7:0]  red_d;
  logic [7:0]  green_d;
  logic [7:0]  blue_d;

  // Upper index bits beyond the palette size and the alpha/unused top bit are ignored.
  logic color_unused;
  assign color_unused = ^{color_in[13:ADDR_W], pix_word[15]};

  // ---------------------------------------------------------------------------
  // CPU access FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    dtack_d = cpu_dtack_n;
    dout_d  = cpu_dout;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        // The pixel path owns the port on ce_pixel cycles; the CPU waits at most one clk.
        if (cs && !ce_pixel) begin
          grant   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (rd_q) dout_d = ram_q;
        dtack_d = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        // A new access needs cs to drop first, so hold dtack until then.
        if (!cs) begin
          dtack_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_q        <= 1'b0;
      cpu_dout    <= 16'h0000;
      cpu_dtack_n <= 1'b1;
    end else begin
      state       <= state_d;
      cpu_dout    <= dout_d;
      cpu_dtack_n <= dtack_d;
      if (grant) rd_q <= cpu_rw;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-ported palette RAM, time-shared between pixel reads and CPU grants
  // ---------------------------------------------------------------------------
  assign ram_addr = grant ? cpu_addr : color_in[ADDR_W-1:0];
  // Reset wins over a grant landing on the same edge: that write is dropped.
  assign ram_we   = (grant && !cpu_rw && !reset) ? ~cpu_ds_n : 2'b00;

  always_ff @(posedge clk) begin
    if (ram_we[1]) mem[ram_addr][15:8] <= cpu_din[15:8];
    if (ram_we[0]) mem[ram_addr][7:0]  <= cpu_din[7:0];
    ram_q <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    red_d   = 8'h00;
    green_d = 8'h00;
    blue_d  = 8'h00;
    if (!(hb1 || vb1)) begin
      if (rgb_format) begin
        red_d   = {pix_word[14:10], pix_word[14:12]};
        green_d = {pix_word[9:5],   pix_word[9:7]};
        blue_d  = {pix_word[4:0],   pix_word[4:2]};
      end else begin
        red_d   = {pix_word[11:8], pix_word[11:8]};
        green_d = {pix_word[7:4],  pix_word[7:4]};
        blue_d  = {pix_word[3:0],  pix_word[3:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_pend   <= 1'b0;
      pix_word   <= 16'h0000;
      hb1        <= 1'b1;
      vb1        <= 1'b1;
      red        <= 8'h00;
      green      <= 8'h00;
      blue       <= 8'h00;
      hblank_out <= 1'b1;
      vblank_out <= 1'b1;
    end else begin
      // ram_q holds the pixel word only for the clk right after the ce_pixel read;
      // a CPU grant in that clk will overwrite it on the following edge.
      pix_pend <= ce_pixel;
      if (pix_pend) pix_word <= ram_q;
      if (ce_pixel) begin
        hb1        <= hblank_in;
        vb1        <= vblank_in;
        red        <= red_d;
        green      <= green_d;
        blue       <= blue_d;
        hblank_out <= hb1;
        vblank_out <= vb1;
      end
    end
  end

  // Back-to-back ce_pixel would let the pixel word be lost before pix_word captures it.
  ce_pixel_spacing: assert property (@(posedge clk) disable iff (reset) ce_pixel |=> !ce_pixel);

endmodule

// File: doc/palette_dac.md
Name: palette_dac

Overview:
Palette lookup and colour-expansion stage directly downstream of the priority mixer. It takes the mixer's 14-bit colour index each pixel, reads a 16-bit entry from an internal palette RAM and emits 8-bit R/G/B with matching delayed blanking. The palette RAM is single-ported and shared with a 68000-style CPU interface that uses DTACK-based handshaking. Pixel reads always win arbitration.

Parameters:
ADDR_W, 12, palette index width in bits; the RAM holds 2**ADDR_W x 16-bit entries.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_pixel  in  1  pixel clock enable; never asserted on two consecutive clk cycles
cs  in  1  CPU chip select for palette space; held until dtack_n is seen low
cpu_addr  in  ADDR_W  CPU word address
cpu_rw  in  1  1 = read, 0 = write
cpu_ds_n  in  2  byte strobes, active low; [1] = bits 15:8, [0] = bits 7:0
cpu_din  in  16  CPU write data
cpu_dout  out  16  CPU read data
cpu_dtack_n  out  1  access acknowledge, active low
color_in  in  14  colour index from the priority mixer; bits [ADDR_W-1:0] are used
hblank_in  in  1  horizontal blank aligned with color_in
vblank_in  in  1  vertical blank aligned with color_in
rgb_format  in  1  0 = xRGB444, 1 = xRGB555
red  out  8  red output
green  out  8  green output
blue  out  8  blue output
hblank_out  out  1  delayed hblank
vblank_out  out  1  delayed vblank

Behaviour:
- Reset state:
  - cpu_dout = 0, cpu_dtack_n = 1.
  - red/green/blue = 0; hblank_out = vblank_out = 1.
  - CPU FSM = IDLE.
  - RAM contents are not cleared.
- Pixel path:
  - On a ce_pixel cycle, the RAM port is driven with color_in[ADDR_W-1:0], and hblank_in/vblank_in are captured into stage-1 registers.
  - On the following clk, the RAM output is latched into pix_word.
  - On the next ce_pixel, outputs load from pix_word and the stage-1 blanks.
  - Latency is exactly one pixel: an index presented at ce_pixel edge k appears on the outputs after ce_pixel edge k+1.
- Colour conversion, applied at output load using rgb_format as sampled at that edge:
  - 444: R = w[11:8], G = w[7:4], B = w[3:0]; each channel expands to 8 bits as {c4,c4}. w[15:12] is ignored.
  - 555: R = w[14:10], G = w[9:5], B = w[4:0]; each channel expands as {c5,c5[4:2]}. w[15] is ignored.
  - If either stage-1 blank bit is 1, red/green/blue load 0. The blank outputs still load normally.
- CPU FSM with states IDLE, CAPTURE and HOLD:
  - IDLE:
    - cs=1 and ce_pixel=0 makes this a grant cycle. The CPU owns the RAM port this cycle, and the state moves to CAPTURE.
    - On a grant-cycle write (cpu_rw=0), each byte lane is written only where its ds_n bit is 0. If both strobes are 1, nothing is written, but the handshake still completes.
    - cs=1 and ce_pixel=1 means the CPU waits in IDLE. It is granted on the next ce_pixel=0 cycle, so the wait is at most 1 clk.
  - CAPTURE: for reads, cpu_dout is loaded with the RAM data. For writes, cpu_dout is unchanged. cpu_dtack_n is set to 0 and the state moves to HOLD.
  - HOLD: cpu_dtack_n stays 0 while cs=1. When cs=0, cpu_dtack_n is set to 1 and the state moves to IDLE. A new access therefore needs cs to fall and rise again.
- Access timing:
  - Minimum latency from the cs-rise cycle to cpu_dtack_n low is 2 clk; the maximum is 3 clk.
  - A CPU read of an address written in the same or previous grant returns the new data.
- Simultaneous pixel read and CPU write to the same entry cannot occur, because the port is time-shared. A pixel read after a CPU write returns the new data.
- Reset mid-operation:
  - Reset has precedence. A write whose grant cycle coincides with reset is not performed.
  - The FSM returns to IDLE and cpu_dtack_n goes to 1 immediately (on the next edge).
  - The pixel pipeline outputs take their reset values.
- Behaviour is undefined if ce_pixel is asserted on consecutive cycles. An assertion flags this condition in simulation.

Test Plan:
- Write 0x1234 to addr 0x005 (both strobes), then a read-back gives cpu_dout=0x1234. Next, write 0xABCD with ds_n=2'b01 (upper byte only); the read-back gives 0xAB34. cpu_dtack_n is low within 3 clk of cs each time and returns high 1 clk after cs drops.
- Pixel latency, with palette[0x010]=0x0F80 and 444 format: present color_in=0x010 at ce edge k. After edge k+1, outputs are R=0xFF, G=0x88, B=0x00. The outputs at edge k show the previous pixel.
- 555 conversion, with palette[0x020]=0x7C1F: outputs are R=0xFF, G=0x00, B=0xFF. Then palette[0x021]=0x0421 gives R=0x08, G=0x08, B=0x08.
- Blanking: drive vblank_in=1 with a nonzero palette entry. One pixel later, RGB=0 and vblank_out=1. Deasserting vblank_in restores colour one pixel later.
- Contention, with ce_pixel every 2nd clk: run continuous pixel reads while the CPU does 64 back-to-back writes and reads with random data. All CPU read-backs must match. Pixel outputs must equal the model palette with one-pixel latency, with no dropped or corrupted pixels.
- Reset mid-access: raise cs for a write of 0xFFFF to addr 0x030, with reset asserted on the grant cycle. cpu_dtack_n must be 1 after reset. After reset, a read of 0x030 returns its pre-reset value.
